game_timer: RTL and testbench

- Countdown game timer for the two-player timed sequence-matching memory game.
- Loads an 11-bit binary start time in seconds and converts it to three BCD digits.
- Decrements the digits once per second using an internal prescaler of the single system clock.
- Raises Stop when the time reaches 000 so the game controller can end the round; the digits drive the 7-segment decoders.

---
 rtl/game_timer_pkg.sv | 20 ++
 rtl/game_timer_bin2bcd.sv | 39 +++
 rtl/game_timer.sv | 142 ++++++++++++++
 tb/tb_game_timer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/game_timer_pkg.sv
// ---------------------------------------------------------------------------
// game_timer_pkg
// Shared types and constants for the countdown game timer.
//   state_e          : timer FSM states (2-bit encoding)
//   bcd_t            : one BCD digit (0-9 held in 4 bits)
//   MAX_TIME_DEFAULT : largest start time representable on three digits
// ---------------------------------------------------------------------------
package game_timer_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam int MAX_TIME_DEFAULT = 999;

endpackage : game_timer_pkg

// File: rtl/game_timer_bin2bcd.sv
// ---------------------------------------------------------------------------
// bin2bcd
// Combinational double-dabble conversion of an 11-bit binary value into
// three BCD digits. The caller clamps the input to <= 999 beforehand, so
// the result always fits in three digits.
// Ports:
//   i_bin   11-bit unsigned binary input (<= 999)
//   o_ones  BCD ones digit
//   o_tens  BCD tens digit
//   o_hund  BCD hundreds digit
// ---------------------------------------------------------------------------
module bin2bcd
  import game_timer_pkg::*;
(
  input  logic [10:0] i_bin,
  output bcd_t        o_ones,
  output bcd_t        o_tens,
  output bcd_t        o_hund
);

  // Working register: {hundreds, tens, ones, binary} = 12 + 11 bits.
  logic [22:0] w_work;

  always_comb begin
    w_work = {12'd0, i_bin};
    for (int i = 0; i < 11; i++) begin
      // Add 3 to any digit >= 5 so the following shift carries correctly.
      if (w_work[14:11] >= 4'd5) w_work[14:11] = w_work[14:11] + 4'd3;
      if (w_work[18:15] >= 4'd5) w_work[18:15] = w_work[18:15] + 4'd3;
      if (w_work[22:19] >= 4'd5) w_work[22:19] = w_work[22:19] + 4'd3;
      w_work = {w_work[21:0], 1'b0};
    end
  end

  assign o_ones = w_work[14:11];
  assign o_tens = w_work[18:15];
  assign o_hund = w_work[22:19];

endmodule : bin2bcd

// File: rtl/game_timer.sv
// ---------------------------------------------------------------------------
// game_timer
// Countdown timer for the memory game. Loads a start time in seconds,
// clamps it to MAX_TIME, shows it as three BCD digits and counts down once
// every TICKS_PER_SEC clocks. Stop rises when the count reaches 000 and
// stays high until reset.
// Ports:
//   Clk          system clock, rising edge
//   Rst          asynchronous active-low reset
//   In           start time in seconds (sampled only in LOAD)
//   Out1/2/3     BCD ones / tens / hundreds digits
//   Stop         registered countdown-expired flag
//   o_dbg_state  current FSM state, for observation only
// ---------------------------------------------------------------------------
module game_timer
  import game_timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int MAX_TIME      = MAX_TIME_DEFAULT
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [10:0] In,
  output logic [3:0]  Out1,
  output logic [3:0]  Out2,
  output logic [3:0]  Out3,
  output logic        Stop,
  output logic [1:0]  o_dbg_state
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICKS_PER_SEC - 1);

  state_e        r_state, w_state_nxt;
  logic [PW-1:0] r_presc, w_presc_nxt;
  bcd_t          r_d1, r_d2, r_d3;
  bcd_t          w_d1_nxt, w_d2_nxt, w_d3_nxt;
  logic          r_stop, w_stop_nxt;

  logic [10:0]   w_clamped;
  bcd_t          w_ld1, w_ld2, w_ld3;
  logic          w_tick;

  assign w_clamped = (In > 11'(MAX_TIME)) ? 11'(MAX_TIME) : In;

  bin2bcd u_bin2bcd (
    .i_bin  (w_clamped),
    .o_ones (w_ld1),
    .o_tens (w_ld2),
    .o_hund (w_ld3)
  );

  assign w_tick = (r_presc == TICK_LAST);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= ST_LOAD;
      r_presc <= '0;
      r_d1    <= '0;
      r_d2    <= '0;
      r_d3    <= '0;
      r_stop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_presc <= w_presc_nxt;
      r_d1    <= w_d1_nxt;
      r_d2    <= w_d2_nxt;
      r_d3    <= w_d3_nxt;
      r_stop  <= w_stop_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_d1_nxt    = r_d1;
    w_d2_nxt    = r_d2;
    w_d3_nxt    = r_d3;
    w_stop_nxt  = r_stop;

    unique case (r_state)
      ST_LOAD: begin
        w_d1_nxt    = w_ld1;
        w_d2_nxt    = w_ld2;
        w_d3_nxt    = w_ld3;
        w_presc_nxt = '0;
        if (w_clamped == 11'd0) begin
          w_state_nxt = ST_DONE;
          w_stop_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end

      ST_RUN: begin
        if (w_tick) begin
          w_presc_nxt = '0;
          if (r_d3 == 4'd0 && r_d2 == 4'd0 && r_d1 == 4'd1) begin
            // Last second elapsed: land on 000 and expire on the same edge.
            w_d1_nxt    = 4'd0;
            w_state_nxt = ST_DONE;
            w_stop_nxt  = 1'b1;
          end else if (r_d1 != 4'd0) begin
            w_d1_nxt = r_d1 - 4'd1;
          end else begin
            // Ones borrow; RUN never holds 000, so a nonzero digit exists above.
            w_d1_nxt = 4'd9;
            if (r_d2 != 4'd0) begin
              w_d2_nxt = r_d2 - 4'd1;
            end else begin
              w_d2_nxt = 4'd9;
              w_d3_nxt = r_d3 - 4'd1;
            end
          end
        end else begin
          w_presc_nxt = r_presc + PW'(1);
        end
      end

      ST_DONE: begin
        w_presc_nxt = '0;
        w_d1_nxt    = 4'd0;
        w_d2_nxt    = 4'd0;
        w_d3_nxt    = 4'd0;
        w_stop_nxt  = 1'b1;
      end

      default: begin
        w_state_nxt = ST_LOAD;
        w_presc_nxt = '0;
        w_stop_nxt  = 1'b0;
      end
    endcase
  end

  assign Out1        = r_d1;
  assign Out2        = r_d2;
  assign Out3        = r_d3;
  assign Stop        = r_stop;
  assign o_dbg_state = r_state;

endmodule : game_timer

// File: tb/tb_game_timer.sv
// ---------------------------------------------------------------------------
// tb_game_timer
// Directed bench for game_timer with TICKS_PER_SEC = 4. Inputs change on the
// falling edge; outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_game_timer;
  import game_timer_pkg::*;

  logic        Clk;
  logic        Rst;
  logic [10:0] In;
  logic [3:0]  Out1, Out2, Out3;
  logic        Stop;
  logic [1:0]  o_dbg_state;

  int checks = 0;
  int errors = 0;

  game_timer #(.TICKS_PER_SEC(4), .MAX_TIME(999)) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .In          (In),
    .Out1        (Out1),
    .Out2        (Out2),
    .Out3        (Out3),
    .Stop        (Stop),
    .o_dbg_state (o_dbg_state)
  );

  // Clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Compare the three digits as one 12-bit BCD word, plus Stop.
  task automatic chk(input string tag, input logic [11:0] exp_bcd, input logic exp_stop);
    logic [11:0] got;
    got = {Out3, Out2, Out1};
    checks++;
    assert (got === exp_bcd) else begin
      errors++;
      $error("FAIL %s digits got %03h exp %03h", tag, got, exp_bcd);
    end
    checks++;
    assert (Stop === exp_stop) else begin
      errors++;
      $error("FAIL %s stop got %0b exp %0b", tag, Stop, exp_stop);
    end
  endtask

  task automatic chk_state(input string tag, input state_e exp_st);
    checks++;
    assert (o_dbg_state === exp_st) else begin
      errors++;
      $error("FAIL %s state got %0d exp %0d", tag, o_dbg_state, exp_st);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Hold reset for two clocks with the given start time, release between
  // edges, and return just after the LOAD edge.
  task automatic load(input logic [10:0] val);
    Rst = 1'b0;
    In  = val;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    step(1);
  endtask

  initial begin
    Rst = 1'b0;
    In  = 11'd0;
    #2;
    chk("reset_async", 12'h000, 1'b0);
    chk_state("reset_state", ST_LOAD);

    // Load 25 and count down to zero.
    load(11'd25);
    chk("load25", 12'h025, 1'b0);
    chk_state("load25_state", ST_RUN);
    step(3);
    chk("load25_pre_tick", 12'h025, 1'b0);
    step(1);
    chk("load25_tick1", 12'h024, 1'b0);
    step(95);
    chk("load25_99", 12'h001, 1'b0);
    step(1);
    chk("load25_100", 12'h000, 1'b1);
    chk_state("load25_done", ST_DONE);
    step(10);
    chk("load25_hold", 12'h000, 1'b1);

    // Clamp above MAX_TIME.
    load(11'd1500);
    chk("clamp", 12'h999, 1'b0);
    step(4);
    chk("clamp_tick", 12'h998, 1'b0);

    // Borrow cases.
    load(11'd120);
    chk("b120", 12'h120, 1'b0);
    step(4);
    chk("b120_tick", 12'h119, 1'b0);
    load(11'd100);
    chk("b100", 12'h100, 1'b0);
    step(4);
    chk("b100_tick", 12'h099, 1'b0);
    step(4);
    chk("b100_tick2", 12'h098, 1'b0);

    // Zero load expires on the LOAD edge.
    load(11'd0);
    chk("zero", 12'h000, 1'b1);
    chk_state("zero_state", ST_DONE);
    step(5);
    chk("zero_hold", 12'h000, 1'b1);

    // In changes every clock after load and must be ignored.
    load(11'd7);
    chk("ign_load", 12'h007, 1'b0);
    for (int k = 1; k <= 28; k++) begin
      @(negedge Clk);
      In = In + 11'd1;
      step(1);
      if (k < 28) chk($sformatf("ign_%0d", k), 12'(7 - k / 4), 1'b0);
      else        chk("ign_28", 12'h000, 1'b1);
    end

    // Asynchronous reset in the middle of RUN.
    load(11'd50);
    step(5);
    chk("mid_before", 12'h049, 1'b0);
    #2;
    Rst = 1'b0;
    #1;
    chk("mid_reset", 12'h000, 1'b0);
    chk_state("mid_reset_state", ST_LOAD);
    In = 11'd3;
    @(negedge Clk);
    Rst = 1'b1;
    step(1);
    chk("reload3", 12'h003, 1'b0);
    step(12);
    chk("reload3_done", 12'h000, 1'b1);

    // Reset out of DONE clears Stop at once.
    #2;
    Rst = 1'b0;
    #1;
    chk("done_reset", 12'h000, 1'b0);
    chk_state("done_reset_state", ST_LOAD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_game_timer
